hilo_div_ctrl: RTL

//  Iterative restoring divider that sequences the HI/LO register pair for DIV and DIVU.

---
 rtl/hilo_div_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hilo_div_ctrl.sv
// Iterative restoring divider driving the HI/LO write port (HI = remainder, LO = quotient).
// Optional macro DIV_EARLY_EN: skip the iteration when |dividend| < |divisor|.
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    output logic             stallreq_o,
    output logic             ready_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] step_rem, step_quot;
    logic [WIDTH-1:0] fix_rem, fix_quot;

    assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The running remainder is always below the divisor, so bit WIDTH of the
    // trial difference is a reliable "went negative" flag.
    assign shifted   = {rem_q, quot_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvsr_q};
    assign step_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign step_quot = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
    assign fix_quot  = quot_neg_q ? -step_quot : step_quot;
    assign fix_rem   = rem_neg_q  ? -step_rem  : step_rem;

    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment infer latches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stallreq_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    stallreq_o = 1'b1;
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
`ifdef DIV_EARLY_EN
                    end else if (abs1 < abs2) begin
                        state_d = S_END;
                        hi_d    = opdata1_i;
                        lo_d    = '0;
`endif
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        rem_d      = '0;
                        quot_d     = abs1;
                        dvsr_d     = abs2;
                        quot_neg_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        rem_neg_d  = signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
            end
            S_BYZERO: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
                    hi_d    = '0;
                    lo_d    = '0;
                end
            end
            S_ON: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_END;
                        hi_d    = fix_rem;
                        lo_d    = fix_quot;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign ready_o   = (state_q == S_END);
    assign hilo_we_o = (state_q == S_END);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule
